// File: rtl/uart_pkg.sv
// Shared UART receive types and defaults.
// The parity helper is used by uart_rx_frame only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Even parity bit for a word zero-extended to 64 bits.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the rx pin plus falling-edge detector.
// All flops reset high so that no edge is reported out of reset.
module uart_rx_sync (
    input  logic clock,
    input  logic reset,
    input  logic rx_serial,
    output logic rx_sync,
    output logic rx_fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchroniser chain plus one history flop for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            prev_r <= 1'b1;
        end else begin
            meta_r <= rx_serial;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign rx_sync = sync_r;
    assign rx_fall = prev_r & ~sync_r;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: oversampled midpoint sampling, stop check, valid/ready output.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_serial,
    input  logic                 sample_tick,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 parity_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic                 rx_sync_s;
    logic                 rx_fall_s;
    rx_state_t            state_r;
    rx_state_t            state_next_s;
    logic [TW-1:0]        tick_cnt_r;
    logic [BW-1:0]        bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 mid_hit_s;
    logic                 end_hit_s;
    logic                 last_bit_s;
    logic                 tick_clr_s;
    logic                 shift_en_s;
    logic                 bit_clr_s;
    logic                 stop_ok_s;
    logic                 stop_bad_s;
    logic                 commit_ok_s;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_valid_r;
    logic                 frame_err_r;
    logic                 overrun_err_r;
`ifdef UART_RX_PARITY_EN
    logic                 par_en_s;
    logic                 par_bad_r;
    logic                 parity_err_r;
`endif

    uart_rx_sync u_sync (
        .clock     (clock),
        .reset     (reset),
        .rx_serial (rx_serial),
        .rx_sync   (rx_sync_s),
        .rx_fall   (rx_fall_s)
    );

    assign mid_hit_s   = sample_tick & (tick_cnt_r == TICK_MID);
    assign end_hit_s   = sample_tick & (tick_cnt_r == TICK_END);
    assign last_bit_s  = (bit_cnt_r == BIT_LAST);
    assign commit_ok_s = stop_ok_s & (~rx_valid_r | rx_ready);

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (rx_fall_s) state_next_s = START;
                else           state_next_s = IDLE;
            end
            START: begin
                if (mid_hit_s) begin
                    // A start bit that is high again at its midpoint was a glitch.
                    if (rx_sync_s) state_next_s = IDLE;
                    else           state_next_s = DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (end_hit_s && last_bit_s) begin
`ifdef UART_RX_PARITY_EN
                    state_next_s = PARITY;
`else
                    state_next_s = STOP;
`endif
                end else begin
                    state_next_s = DATA;
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (end_hit_s) state_next_s = STOP;
                else           state_next_s = PARITY;
`else
                state_next_s = IDLE;
`endif
            end
            STOP: begin
                if (end_hit_s) state_next_s = IDLE;
                else           state_next_s = STOP;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM output decode: counter controls and sample strobes.
    always_comb begin
        tick_clr_s = 1'b0;
        shift_en_s = 1'b0;
        bit_clr_s  = 1'b0;
        stop_ok_s  = 1'b0;
        stop_bad_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en_s   = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                tick_clr_s = rx_fall_s;
            end
            START: begin
                tick_clr_s = mid_hit_s;
                bit_clr_s  = mid_hit_s & ~rx_sync_s;
            end
            DATA: begin
                tick_clr_s = end_hit_s;
                shift_en_s = end_hit_s;
            end
            PARITY: begin
                tick_clr_s = end_hit_s;
`ifdef UART_RX_PARITY_EN
                par_en_s   = end_hit_s;
`endif
            end
            STOP: begin
                tick_clr_s = end_hit_s;
                stop_ok_s  = end_hit_s & rx_sync_s;
                stop_bad_s = end_hit_s & ~rx_sync_s;
            end
            default: begin
                tick_clr_s = 1'b1;
            end
        endcase
    end

    // Tick/bit counters and the right-shifting deserialiser.
    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt_r <= {TW{1'b0}};
            bit_cnt_r  <= {BW{1'b0}};
            shift_r    <= {DATA_BITS{1'b0}};
        end else begin
            if (tick_clr_s)       tick_cnt_r <= {TW{1'b0}};
            else if (sample_tick) tick_cnt_r <= tick_cnt_r + TW'(1);
            if (bit_clr_s)        bit_cnt_r <= {BW{1'b0}};
            else if (shift_en_s)  bit_cnt_r <= bit_cnt_r + BW'(1);
            if (shift_en_s)       shift_r <= {rx_sync_s, shift_r[DATA_BITS-1:1]};
        end
    end

    // Commit into the output holding register and error pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_data_r     <= {DATA_BITS{1'b0}};
            rx_valid_r    <= 1'b0;
            frame_err_r   <= 1'b0;
            overrun_err_r <= 1'b0;
        end else begin
            frame_err_r   <= stop_bad_s;
            overrun_err_r <= stop_ok_s & rx_valid_r & ~rx_ready;
            if (commit_ok_s) begin
                rx_data_r  <= shift_r;
                rx_valid_r <= 1'b1;
            end else if (rx_valid_r && rx_ready) begin
                rx_valid_r <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity sample is remembered until the stop bit decides the commit.
    always_ff @(posedge clock) begin
        if (reset) begin
            par_bad_r    <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            if (par_en_s) par_bad_r <= (rx_sync_s != even_parity(64'(shift_r)));
            parity_err_r <= stop_ok_s & par_bad_r;
        end
    end

    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign frame_err   = frame_err_r;
    assign overrun_err = overrun_err_r;

endmodule
